// File: rtl/calc_op_sequencer.sv
// Sequenced add/subtract/multiply unit: shift-add multiply, clamp to 9999,
// then a bit-serial double-dabble pass feeding registered BCD outputs.
module calc_op_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [12:0] A,
  input  logic [12:0] B,
  output logic        busy,
  output logic        done,
  output logic [13:0] sum,
  output logic        neg,
  output logic        ovf,
  output logic [3:0]  ONES,
  output logic [3:0]  TENS,
  output logic [3:0]  HUNDREDS,
  output logic [3:0]  THOUSANDS
);
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_CONV, S_DONE} state_t;
  localparam logic [13:0] MAXV = 14'd9999;

  state_t      r_state;
  logic [12:0] r_a, r_b;
  logic [1:0]  r_op;
  logic [25:0] r_prod, r_mcand;
  logic [12:0] r_mplier;
  logic [3:0]  r_cnt;
  logic [13:0] r_res, r_bin;
  logic        r_neg_p, r_ovf_p;
  logic [14:0] r_bcd;

  logic [13:0] w_add;
  logic [25:0] w_prod_nxt;
  logic [14:0] w_adj;
  logic [15:0] w_dd;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Thousands digit never exceeds 4 before the last shift (result < 10000),
  // so it needs no add-3 stage and only 3 bits of storage.
  always_comb begin
    w_add      = {1'b0, r_a} + {1'b0, r_b};
    w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : 26'd0);
    w_adj      = {r_bcd[14:12], add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    w_dd       = {w_adj, r_bin[13]};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_a <= '0; r_b <= '0; r_op <= '0;
      r_prod <= '0; r_mcand <= '0; r_mplier <= '0; r_cnt <= '0;
      r_res <= '0; r_bin <= '0; r_neg_p <= 1'b0; r_ovf_p <= 1'b0; r_bcd <= '0;
      busy <= 1'b0; done <= 1'b0; sum <= '0; neg <= 1'b0; ovf <= 1'b0;
      ONES <= '0; TENS <= '0; HUNDREDS <= '0; THOUSANDS <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a <= A; r_b <= B; r_op <= op;
            r_prod <= '0; r_mcand <= {13'd0, A}; r_mplier <= B; r_cnt <= '0;
            busy <= 1'b1;
            r_state <= (op == 2'b10) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op == 2'b01) begin
            r_res   <= (r_a >= r_b) ? {1'b0, r_a - r_b} : {1'b0, r_b - r_a};
            r_bin   <= (r_a >= r_b) ? {1'b0, r_a - r_b} : {1'b0, r_b - r_a};
            r_neg_p <= (r_a < r_b);
            r_ovf_p <= 1'b0;
          end else begin
            r_res   <= (w_add > MAXV) ? MAXV : w_add;
            r_bin   <= (w_add > MAXV) ? MAXV : w_add;
            r_neg_p <= 1'b0;
            r_ovf_p <= (w_add > MAXV);
          end
          r_bcd <= '0; r_cnt <= '0;
          r_state <= S_CONV;
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= {r_mcand[24:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[12:1]};
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == 4'd12) begin
            r_res   <= (w_prod_nxt > {12'd0, MAXV}) ? MAXV : w_prod_nxt[13:0];
            r_bin   <= (w_prod_nxt > {12'd0, MAXV}) ? MAXV : w_prod_nxt[13:0];
            r_neg_p <= 1'b0;
            r_ovf_p <= (w_prod_nxt > {12'd0, MAXV});
            r_bcd <= '0; r_cnt <= '0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd <= w_dd[14:0];
          r_bin <= {r_bin[12:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd13) begin
            sum <= r_res; neg <= r_neg_p; ovf <= r_ovf_p;
            THOUSANDS <= w_dd[15:12]; HUNDREDS <= w_dd[11:8];
            TENS <= w_dd[7:4]; ONES <= w_dd[3:0];
            busy <= 1'b0; done <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: latency, results, BCD digits,
// start-while-busy, and asynchronous clear mid-operation.
module tb_calc_op_sequencer;
  logic        clk = 1'b0, clr = 1'b1, start = 1'b0;
  logic [1:0]  op = '0;
  logic [12:0] A = '0, B = '0;
  logic        busy, done, neg, ovf;
  logic [13:0] sum;
  logic [3:0]  ONES, TENS, HUNDREDS, THOUSANDS;
  int n_chk = 0, n_fail = 0;

  calc_op_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .sum(sum), .neg(neg), .ovf(ovf),
    .ONES(ONES), .TENS(TENS), .HUNDREDS(HUNDREDS), .THOUSANDS(THOUSANDS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one op; p1/p2 are cycle numbers in which a stray start is raised.
  task automatic run_op(input string tag, input logic [12:0] a, input logic [12:0] b,
                        input logic [1:0] o, input int elat, input int esum,
                        input bit eneg, input bit eovf, input int p1, input int p2);
    int lat;
    lat = 0;
    @(negedge clk);
    A = a; B = b; op = o; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      start = 1'b0;
      A = 13'($urandom); B = 13'($urandom); op = 2'($urandom);
      if (k == p1 || k == p2) start = 1'b1;
      if (k == 1) chk({tag, ".busy1"}, 32'(busy), 1);
      if (done) begin lat = k; break; end
    end
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".busyD"}, 32'(busy), 0);
    chk({tag, ".sum"}, 32'(sum), esum);
    chk({tag, ".neg"}, 32'(neg), 32'(eneg));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
    chk({tag, ".bcd"}, {16'd0, THOUSANDS, HUNDREDS, TENS, ONES},
        {16'd0, 4'((esum / 1000) % 10), 4'((esum / 100) % 10), 4'((esum / 10) % 10), 4'(esum % 10)});
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".doneOnce"}, 32'(done), 0);
    chk({tag, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    int ndone;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.sum", {14'd0, sum, neg, ovf, THOUSANDS, HUNDREDS, TENS, ONES}, 0);
    @(negedge clk); clr = 1'b0;

    run_op("add",    13'd1234, 13'd4321, 2'b00, 16, 5555, 0, 0, 0, 0);
    run_op("subneg", 13'd100,  13'd250,  2'b01, 16, 150,  1, 0, 0, 0);
    run_op("subeq",  13'd250,  13'd250,  2'b01, 16, 0,    0, 0, 0, 0);
    run_op("mul",    13'd99,   13'd101,  2'b10, 28, 9999, 0, 0, 0, 0);
    run_op("mulovf", 13'd100,  13'd100,  2'b10, 28, 9999, 0, 1, 0, 0);
    run_op("mulz",   13'd8191, 13'd0,    2'b10, 28, 0,    0, 0, 0, 0);
    run_op("mulmid", 13'd37,   13'd53,   2'b10, 28, 1961, 0, 0, 0, 0);
    run_op("addovf", 13'd8191, 13'd8191, 2'b00, 16, 9999, 0, 1, 0, 0);
    run_op("op11",   13'd12,   13'd30,   2'b11, 16, 42,   0, 0, 0, 0);
    run_op("zero",   13'd0,    13'd0,    2'b00, 16, 0,    0, 0, 0, 0);
    run_op("busyst", 13'd1234, 13'd4321, 2'b00, 16, 5555, 0, 0, 5, 16);
    run_op("subpos", 13'd8191, 13'd1,    2'b01, 16, 8190, 0, 0, 0, 0);

    // Abort a multiply in cycle 7 with an asynchronous clear.
    @(negedge clk);
    A = 13'd99; B = 13'd101; op = 2'b10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort.busyPre", 32'(busy), 1);
    clr = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.outs", {14'd0, sum, neg, ovf, THOUSANDS, HUNDREDS, TENS, ONES}, 0);
    @(negedge clk); clr = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort.noDone", ndone, 0);
    run_op("post",   13'd5,    13'd7,    2'b00, 16, 12,   0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_op_sequencer.md
CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: operation request, one-cycle pulse from the control FSM.
REQ-004 SHALL have port op, input, 2 bits: operation select; 00 add, 01 subtract, 10 multiply, 11 treated as add.
REQ-005 SHALL have ports A and B, input, 13 bits each: unsigned operands, 0..8191.
REQ-006 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port sum, output, 14 bits: result magnitude, 0..9999.
REQ-009 SHALL have port neg, output, 1 bit: result negative (subtract only).
REQ-010 SHALL have port ovf, output, 1 bit: true result exceeded 9999 and was clamped.
REQ-011 SHALL have ports ONES, TENS, HUNDREDS, THOUSANDS, output, 4 bits each: BCD digits of sum.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, MUL, CONV, DONE.
REQ-013 In IDLE with start=1 at an edge, SHALL capture A, B and op at that edge and go to EXEC (op 00/01/11) or MUL (op 10).
REQ-014 SHALL ignore start in every state other than IDLE; no queuing.
REQ-015 Add: SHALL form 14-bit A+B; if the sum exceeds 9999, result is 9999 and ovf=1; neg=0.
REQ-016 Subtract: if A>=B, result is A-B and neg=0; otherwise result is B-A and neg=1; ovf=0.
REQ-017 EXEC SHALL last exactly 1 cycle, then go to CONV.
REQ-018 MUL SHALL perform shift-add multiplication, one multiplier bit per cycle, for exactly 13 cycles into a 26-bit product register, then go to CONV.
REQ-019 On leaving MUL, if the product exceeds 9999, result SHALL be 9999 with ovf=1; neg=0.
REQ-020 CONV SHALL convert the 14-bit result to BCD by sequential double-dabble (add-3 where a digit >=5, then shift), one bit per cycle, for exactly 14 cycles, then go to DONE.
REQ-021 DONE SHALL last 1 cycle, assert done=1, then return to IDLE.
REQ-022 sum, neg, ovf and the digit outputs SHALL update only at the edge entering DONE, and SHALL hold until the next DONE or reset.
REQ-023 Latency: done SHALL be high in the 16th cycle after the start edge for add/sub, and in the 28th cycle for multiply.
REQ-024 busy SHALL be 1 in EXEC, MUL and CONV, and 0 in IDLE and DONE.
REQ-025 A start coincident with done (the DONE cycle) SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-026 Operand input changes while busy SHALL NOT affect the result in progress.
REQ-027 Boundaries: 0+0 gives 0 with digits 0,0,0,0; A=B on subtract gives 0 with neg=0; an operand of 0 on multiply gives 0 with ovf=0.

Reset
REQ-028 clr=1 SHALL immediately force IDLE; busy=0, done=0, sum=0, neg=0, ovf=0, all digits 0; internal registers are cleared.
REQ-029 clr asserted mid-operation SHALL abort with no done pulse; the first start after clr deasserts SHALL be processed normally.

Verification
REQ-030 Add: A=1234, B=4321, op=00 -> done in cycle 16; sum=5555, digits 5/5/5/5, neg=0, ovf=0.
REQ-031 Subtract: A=100, B=250, op=01 -> sum=150, neg=1, digits 0/1/5/0 (THOUSANDS..ONES); A=250, B=250 -> 0, neg=0.
REQ-032 Multiply: A=99, B=101, op=10 -> done in cycle 28; sum=9999, ovf=0. A=100, B=100 -> sum=9999, ovf=1. A=8191, B=0 -> 0, ovf=0.
REQ-033 Overflow add: A=8191, B=8191 -> sum=9999, ovf=1, neg=0.
REQ-034 Start while busy: second start pulse during CONV (and during DONE) -> ignored; exactly one done; result matches the first operation.
REQ-035 Reset mid-op: clr pulse during MUL cycle 7 -> all outputs 0 at once, no done; a new add 5+7 then gives 12 in cycle 16.
